ff_sqrt_iter: RTL and testbench

- Sequential GF(2^163) square-root / iterated-squaring engine over the field polynomial x^163+x^7+x^6+x^3+1. This is the inverse direction of the combinational field squarer.
- Square root is computed as sqrt(a) = a^(2^162), that is 162 chained squarings.
- A general a^(2^n) mode is also provided for the Itoh-Tsujii inversion sequencer.
- It sits beside the multiplier/squarer in the ECC point-arithmetic datapath and is controlled by the top-level sequencer through a start/done handshake.

---
 rtl/ff_sqrt_iter_if.sv | 21 ++
 rtl/ff_sqrt_iter.sv | 109 ++++++++++
 tb/tb_ff_sqrt_iter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ff_sqrt_iter_if.sv
// Start/done handshake bundle between the ECC sequencer and the
// GF(2^163) iterated-squaring engine.
interface ff_sqrt_iter_if;
    logic         start;
    logic         sqrt_mode;
    logic [7:0]   count;
    logic [162:0] a;
    logic [162:0] c;
    logic         busy;
    logic         done;

    modport master (
        output start, sqrt_mode, count, a,
        input  c, busy, done
    );

    modport slave (
        input  start, sqrt_mode, count, a,
        output c, busy, done
    );
endinterface

// File: rtl/ff_sqrt_iter.sv
// GF(2^163) square root / a^(2^n) engine, p = x^163+x^7+x^6+x^3+1.
// UNROLL chained squarers per clock; the last step taps the chain early.
module ff_sqr163 (
    input  logic [162:0] x,
    output logic [162:0] y
);
    function automatic logic [162:0] sq(input logic [162:0] v);
        logic [324:0] t;
        t = '0;
        for (int i = 0; i < 163; i++)
            t[2*i] = v[i];
        // x^j = x^(j-163) * (x^7+x^6+x^3+1), folded from the top down
        for (int j = 324; j >= 163; j--) begin
            if (t[j]) begin
                t[j-163] = ~t[j-163];
                t[j-160] = ~t[j-160];
                t[j-157] = ~t[j-157];
                t[j-156] = ~t[j-156];
                t[j]     = 1'b0;
            end
        end
        return t[162:0];
    endfunction

    assign y = sq(x);
endmodule

module ff_sqrt_iter #(
    parameter int UNROLL = 1
) (
    input  logic           clk,
    input  logic           rst,
    ff_sqrt_iter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] U8 = 8'(UNROLL);

    state_t       state;
    logic [162:0] r;
    logic [7:0]   rem;
    logic [162:0] tap [UNROLL+1];
    logic [162:0] r_next;
    logic [7:0]   k;
    logic [7:0]   rem_next;
    logic [7:0]   n_load;

    assign tap[0] = r;

    for (genvar i = 0; i < UNROLL; i++) begin : g_sq
        ff_sqr163 u_sq (
            .x (tap[i]),
            .y (tap[i+1])
        );
    end

    assign k        = (rem < U8) ? rem : U8;
    assign rem_next = rem - k;
    assign n_load   = bus.sqrt_mode ? 8'd162 : bus.count;

    always_comb begin
        r_next = tap[UNROLL];
        for (int i = 1; i < UNROLL; i++)
            if (rem == 8'(i))
                r_next = tap[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            r        <= '0;
            rem      <= '0;
            bus.c    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (bus.start) begin
                        r   <= bus.a;
                        rem <= n_load;
                        if (n_load == 8'd0) begin
                            bus.c    <= bus.a;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    rem <= rem_next;
                    if (rem_next == 8'd0) begin
                        bus.c    <= r_next;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_sqrt_iter.sv
// Random and directed checks of ff_sqrt_iter at UNROLL 1, 2, 3 and 8
// against a shift-and-add GF(2^163) reference model.
module tb_ff_sqrt_iter;
    localparam int ND = 4;

    function automatic int unr(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 8;
    endfunction

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sqrt_mode;
    logic [7:0]   count;
    logic [162:0] a;

    logic [162:0] c_o [ND];
    logic [ND-1:0] busy_o;
    logic [ND-1:0] done_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ff_sqrt_iter_if bus ();
        assign bus.start     = start;
        assign bus.sqrt_mode = sqrt_mode;
        assign bus.count     = count;
        assign bus.a         = a;
        assign c_o[g]        = bus.c;
        assign busy_o[g]     = bus.busy;
        assign done_o[g]     = bus.done;

        ff_sqrt_iter #(.UNROLL(unr(g))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string tag, input logic [162:0] got,
                       input logic [162:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [162:0] mulx(input logic [162:0] v);
        logic top;
        top = v[162];
        v = v << 1;
        if (top) v = v ^ 163'hC9;
        return v;
    endfunction

    function automatic logic [162:0] gf_mul(input logic [162:0] x,
                                            input logic [162:0] y);
        logic [162:0] acc;
        acc = '0;
        for (int i = 162; i >= 0; i--) begin
            acc = mulx(acc);
            if (y[i]) acc = acc ^ x;
        end
        return acc;
    endfunction

    function automatic logic [162:0] pow2n(input logic [162:0] x,
                                           input int n);
        for (int i = 0; i < n; i++)
            x = gf_mul(x, x);
        return x;
    endfunction

    function automatic logic [162:0] rand_a();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    task automatic launch(input logic sm, input logic [7:0] cnt,
                          input logic [162:0] av);
        @(negedge clk);
        start     = 1'b1;
        sqrt_mode = sm;
        count     = cnt;
        a         = av;
        @(posedge clk);
    endtask

    // Called right after the accepting edge; t counts negedges after it.
    task automatic watch(input logic sm, input logic [7:0] cnt,
                         input logic [162:0] exp, input int inj);
        int n;
        int lat [ND];
        int dn_t [ND];
        int dn_c [ND];
        int bz_c [ND];
        n = sm ? 162 : int'(cnt);
        for (int g = 0; g < ND; g++) begin
            lat[g]  = (n + unr(g) - 1) / unr(g);
            dn_t[g] = -1;
            dn_c[g] = 0;
            bz_c[g] = 0;
        end
        for (int t = 0; t <= lat[0] + 2; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
            if (t == inj) begin
                start     = 1'b1;
                sqrt_mode = 1'b1;
                a         = rand_a();
            end
            if (t == inj + 1) start = 1'b0;
            for (int g = 0; g < ND; g++) begin
                if (done_o[g]) begin
                    dn_c[g]++;
                    if (dn_t[g] < 0) dn_t[g] = t;
                end
                if (busy_o[g]) bz_c[g]++;
            end
        end
        for (int g = 0; g < ND; g++) begin
            chk($sformatf("done_cnt u%0d", unr(g)), 163'(dn_c[g]), 163'd1);
            chk($sformatf("done_lat u%0d", unr(g)), 163'(dn_t[g]),
                163'(lat[g]));
            chk($sformatf("busy_cyc u%0d", unr(g)), 163'(bz_c[g]),
                163'(lat[g]));
            chk($sformatf("result u%0d", unr(g)), c_o[g], exp);
        end
    endtask

    initial begin
        logic [162:0] av;
        logic [7:0]   cnt;
        logic         sm;

        rst       = 1'b1;
        start     = 1'b0;
        sqrt_mode = 1'b0;
        count     = '0;
        a         = '0;
        #2;
        for (int g = 0; g < ND; g++) begin
            chk("rst_c", c_o[g], '0);
            chk("rst_busy", 163'(busy_o[g]), '0);
            chk("rst_done", 163'(done_o[g]), '0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        launch(1'b1, 8'd0, 163'd4);
        watch(1'b1, 8'd0, 163'd2, -1);

        av = 163'd1 << 82;
        launch(1'b0, 8'd1, av);
        watch(1'b0, 8'd1, 163'h192, -1);
        launch(1'b1, 8'd0, 163'h192);
        watch(1'b1, 8'd0, av, -1);

        av = rand_a();
        launch(1'b0, 8'd163, av);
        watch(1'b0, 8'd163, av, -1);

        launch(1'b0, 8'd0, 163'h5A);
        @(negedge clk);
        for (int g = 0; g < ND; g++) begin
            chk("b2b_done", 163'(done_o[g]), 163'd1);
            chk("b2b_busy", 163'(busy_o[g]), '0);
            chk("b2b_c", c_o[g], 163'h5A);
        end
        av    = 163'd1 << 81;
        count = 8'd2;
        a     = av;
        @(posedge clk);
        watch(1'b0, 8'd2, pow2n(av, 2), -1);

        av = rand_a();
        launch(1'b1, 8'd0, av);
        watch(1'b1, 8'd0, pow2n(av, 162), 5);

        launch(1'b1, 8'd0, rand_a());
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        for (int g = 0; g < ND; g++) begin
            chk("arst_c", c_o[g], '0);
            chk("arst_busy", 163'(busy_o[g]), '0);
            chk("arst_done", 163'(done_o[g]), '0);
        end
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("arst_nodone", 163'(done_o), '0);
        end
        rst = 1'b0;
        launch(1'b1, 8'd0, 163'd1);
        watch(1'b1, 8'd0, 163'd1, -1);

        for (int i = 0; i < 1000; i++) begin
            av  = rand_a();
            sm  = ($urandom_range(0, 7) == 0);
            cnt = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 20));
            launch(sm, cnt, av);
            watch(sm, cnt, pow2n(av, sm ? 162 : int'(cnt)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
